// File: rtl/sram_arbiter.sv
// Round-robin two-port arbiter and setup/strobe/hold sequencer for the external async 8-bit SRAM.
// All pad-facing outputs are registered from the next state so no request path reaches the pins combinationally.
module sram_arbiter #(
  parameter int ADDR_W      = 19,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [7:0]        wdata0,
  input  logic [7:0]        wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic [7:0]        rdata,
  output logic              busy,
  output logic [ADDR_W-1:0] sram_addr,
  output logic              sram_ce_n,
  output logic              sram_we_n,
  output logic              sram_oe_n,
  output logic [7:0]        sram_dout,
  output logic              sram_doe,
  input  logic [7:0]        sram_din
);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_e;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              grant_q, grant_d;
  logic              lastGrant_q, lastGrant_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        wdata_q, wdata_d;

  logic ceN_q, ceN_d;
  logic weN_q, weN_d;
  logic oeN_q, oeN_d;
  logic doe_q, doe_d;
  logic ack0_q, ack0_d;
  logic ack1_q, ack1_d;
  logic busy_q, busy_d;
  logic [7:0] rdata_q;
  logic rdCapture;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      grant_q     <= 1'b0;
      lastGrant_q <= 1'b1;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      ceN_q       <= 1'b1;
      weN_q       <= 1'b1;
      oeN_q       <= 1'b1;
      doe_q       <= 1'b0;
      ack0_q      <= 1'b0;
      ack1_q      <= 1'b0;
      busy_q      <= 1'b0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      grant_q     <= grant_d;
      lastGrant_q <= lastGrant_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      ceN_q       <= ceN_d;
      weN_q       <= weN_d;
      oeN_q       <= oeN_d;
      doe_q       <= doe_d;
      ack0_q      <= ack0_d;
      ack1_q      <= ack1_d;
      busy_q      <= busy_d;
      if (rdCapture) rdata_q <= sram_din;
    end
  end

  // On a tie the port that did not win last time gets the grant.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    grant_d     = grant_q;
    lastGrant_d = lastGrant_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          grant_d     = (req0 && req1) ? ~lastGrant_q : req1;
          lastGrant_d = grant_d;
          we_d        = grant_d ? we1 : we0;
          addr_d      = grant_d ? addr1 : addr0;
          if (we_d) wdata_d = grant_d ? wdata1 : wdata0;
          state_d     = SETUP;
        end
      end
      SETUP: begin
        cnt_d   = 4'(WAIT_CYCLES - 1);
        state_d = STROBE;
      end
      STROBE: begin
        if (cnt_q == 4'd0) state_d = HOLD;
        else cnt_d = cnt_q - 4'd1;
      end
      HOLD:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output values are decoded from the state being entered so they appear registered in that state.
  always_comb begin
    ceN_d     = (state_d == IDLE);
    weN_d     = !((state_d == STROBE) && we_d);
    oeN_d     = !(((state_d == SETUP) || (state_d == STROBE)) && !we_d);
    doe_d     = (state_d != IDLE) && we_d;
    ack0_d    = (state_d == HOLD) && !grant_d;
    ack1_d    = (state_d == HOLD) && grant_d;
    busy_d    = (state_d != IDLE);
    rdCapture = (state_q == STROBE) && (state_d == HOLD) && !we_q;
  end

  assign sram_addr = addr_q;
  assign sram_dout = wdata_q;
  assign sram_ce_n = ceN_q;
  assign sram_we_n = weN_q;
  assign sram_oe_n = oeN_q;
  assign sram_doe  = doe_q;
  assign ack0      = ack0_q;
  assign ack1      = ack1_q;
  assign busy      = busy_q;
  assign rdata     = rdata_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: one instance with a 1-cycle strobe, one with a 3-cycle strobe,
// each backed by a simple byte-wide async SRAM model.
module tb_sram_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n = 1'b0;
  int compared = 0;
  int mismatched = 0;

  logic        req0 = 0, req1 = 0, we0 = 0, we1 = 0;
  logic [18:0] addr0 = '0, addr1 = '0;
  logic [7:0]  wdata0 = '0, wdata1 = '0;
  logic        ack0, ack1, busy, ceN, weN, oeN, doe;
  logic [7:0]  rdata, dout, din;
  logic [18:0] sAddr;
  logic [7:0]  lastRd1 = '0;

  logic        req3 = 0, we3 = 0, tie0 = 0;
  logic [18:0] addr3 = '0, tieAddr = '0;
  logic [7:0]  wdata3 = '0, tieData = '0;
  logic        ack3a, ack3b, busy3, ceN3, weN3, oeN3, doe3;
  logic [7:0]  rdata3, dout3, din3;
  logic [18:0] sAddr3;
  logic        dinOverEn = 0;
  logic [7:0]  dinOver = '0;

  logic [7:0]  mem1 [0:524287];
  logic [7:0]  mem3 [0:524287];
  logic        pokeEn1 = 0, pokeEn3 = 0;
  logic [18:0] pokeAddr = '0;
  logic [7:0]  pokeData = '0;

  sram_arbiter #(.ADDR_W(19), .WAIT_CYCLES(1)) dut1 (
    .clk(clk), .reset_n(reset_n),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata(rdata), .busy(busy),
    .sram_addr(sAddr), .sram_ce_n(ceN), .sram_we_n(weN), .sram_oe_n(oeN),
    .sram_dout(dout), .sram_doe(doe), .sram_din(din)
  );

  sram_arbiter #(.ADDR_W(19), .WAIT_CYCLES(3)) dut3 (
    .clk(clk), .reset_n(reset_n),
    .req0(req3), .req1(tie0), .we0(we3), .we1(tie0),
    .addr0(addr3), .addr1(tieAddr), .wdata0(wdata3), .wdata1(tieData),
    .ack0(ack3a), .ack1(ack3b), .rdata(rdata3), .busy(busy3),
    .sram_addr(sAddr3), .sram_ce_n(ceN3), .sram_we_n(weN3), .sram_oe_n(oeN3),
    .sram_dout(dout3), .sram_doe(doe3), .sram_din(din3)
  );

  // Async SRAM models: reads are combinational while CE and OE are low, writes land while WE is low.
  assign din  = (!ceN && !oeN) ? mem1[sAddr] : 8'h00;
  assign din3 = dinOverEn ? dinOver : ((!ceN3 && !oeN3) ? mem3[sAddr3] : 8'h00);

  always @(negedge clk) begin
    if (pokeEn1) mem1[pokeAddr] <= pokeData;
    else if (!ceN && !weN && doe) mem1[sAddr] <= dout;
    if (pokeEn3) mem3[pokeAddr] <= pokeData;
    else if (!ceN3 && !weN3 && doe3) mem3[sAddr3] <= dout3;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic poke(input bit toDut3, input logic [18:0] a, input logic [7:0] d);
    pokeAddr = a;
    pokeData = d;
    if (toDut3) pokeEn3 = 1'b1; else pokeEn1 = 1'b1;
    @(negedge clk);
    #1 pokeEn1 = 1'b0;
    pokeEn3 = 1'b0;
  endtask

  // One access on the 1-cycle-strobe instance, checking every phase; called at a negedge in IDLE.
  task automatic applyStimulus(input bit port, input logic we, input logic [18:0] a,
                               input logic [7:0] wd, input logic [7:0] expRd);
    if (port) begin req1 = 1; we1 = we; addr1 = a; wdata1 = wd; end
    else      begin req0 = 1; we0 = we; addr0 = a; wdata0 = wd; end
    @(posedge clk);
    @(negedge clk);
    checkOutput("setup ce_n", ceN, 0);
    checkOutput("setup we_n", weN, 1);
    checkOutput("setup oe_n", oeN, we);
    checkOutput("setup doe", doe, we);
    checkOutput("setup addr", sAddr, a);
    checkOutput("setup ack", {ack1, ack0}, 0);
    checkOutput("setup busy", busy, 1);
    if (we) checkOutput("setup dout", dout, wd);
    @(negedge clk);
    checkOutput("strobe we_n", weN, !we);
    checkOutput("strobe oe_n", oeN, we);
    checkOutput("strobe doe", doe, we);
    checkOutput("strobe addr", sAddr, a);
    checkOutput("strobe ack", {ack1, ack0}, 0);
    if (we) checkOutput("strobe dout", dout, wd);
    @(negedge clk);
    checkOutput("hold we_n", weN, 1);
    checkOutput("hold oe_n", oeN, 1);
    checkOutput("hold doe", doe, we);
    checkOutput("hold addr", sAddr, a);
    checkOutput("hold ack", {ack1, ack0}, port ? 2'b10 : 2'b01);
    if (we) checkOutput("hold dout", dout, wd);
    if (!we) begin
      checkOutput("hold rdata", rdata, expRd);
      lastRd1 = expRd;
    end
    @(posedge clk);
    #1 if (port) req1 = 0; else req0 = 0;
    @(negedge clk);
    checkOutput("idle ce_n", ceN, 1);
    checkOutput("idle strobes", {weN, oeN}, 2'b11);
    checkOutput("idle doe", doe, 0);
    checkOutput("idle ack", {ack1, ack0}, 0);
    checkOutput("idle busy", busy, 0);
    checkOutput("idle rdata held", rdata, lastRd1);
  endtask

  // One access on the 3-cycle-strobe instance; optionally changes the read data during the last strobe cycle.
  task automatic applyStimulus3(input logic we, input logic [18:0] a, input logic [7:0] wd,
                                input logic [7:0] expRd, input bit useOver);
    req3 = 1; we3 = we; addr3 = a; wdata3 = wd;
    @(posedge clk);
    for (int i = 1; i <= 6; i++) begin
      if (i == 4 && useOver) begin
        @(posedge clk);
        #1 dinOverEn = 1'b1;
        dinOver = 8'h77;
      end
      @(negedge clk);
      checkOutput($sformatf("w3 ce_n c%0d", i), ceN3, (i == 6));
      checkOutput($sformatf("w3 we_n c%0d", i), weN3, !(we && i >= 2 && i <= 4));
      checkOutput($sformatf("w3 oe_n c%0d", i), oeN3, !(!we && i <= 4));
      checkOutput($sformatf("w3 doe c%0d", i), doe3, (we && i <= 5));
      checkOutput($sformatf("w3 ack c%0d", i), {ack3b, ack3a}, {1'b0, (i == 5)});
      checkOutput($sformatf("w3 busy c%0d", i), busy3, (i <= 5));
      if (i <= 5) checkOutput($sformatf("w3 addr c%0d", i), sAddr3, a);
      if (we && i <= 5) checkOutput($sformatf("w3 dout c%0d", i), dout3, wd);
      if (!we && i >= 5) checkOutput($sformatf("w3 rdata c%0d", i), rdata3, expRd);
      if (i == 5) req3 = 0;
    end
    dinOverEn = 1'b0;
  endtask

  initial begin
    $display("[TB] preload and reset");
    poke(0, 19'h01234, 8'hA5);
    poke(0, 19'h00010, 8'h11);
    poke(0, 19'h00020, 8'h22);
    poke(0, 19'h00100, 8'h5A);
    poke(0, 19'h00200, 8'hC3);
    poke(1, 19'h00ABC, 8'h11);
    @(negedge clk);
    checkOutput("reset strobes", {ceN, weN, oeN}, 3'b111);
    checkOutput("reset doe/ack/busy", {doe, ack1, ack0, busy}, 0);
    checkOutput("reset addr", sAddr, 0);
    checkOutput("reset rdata", rdata, 0);
    reset_n = 1;

    $display("[TB] port 0 read");
    applyStimulus(0, 0, 19'h01234, 8'h00, 8'hA5);

    $display("[TB] port 1 write then readback");
    applyStimulus(1, 1, 19'h7FFFF, 8'h3C, 8'h00);
    checkOutput("mem after write", mem1[19'h7FFFF], 8'h3C);
    applyStimulus(1, 0, 19'h7FFFF, 8'h00, 8'h3C);

    $display("[TB] simultaneous requests from reset");
    reset_n = 0;
    @(negedge clk);
    checkOutput("rr reset addr", sAddr, 0);
    checkOutput("rr reset dout", dout, 0);
    checkOutput("rr reset rdata", rdata, 0);
    reset_n = 1;
    req0 = 1; we0 = 0; addr0 = 19'h00010;
    req1 = 1; we1 = 0; addr1 = 19'h00020;
    @(posedge clk);
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      checkOutput($sformatf("rr ack0 c%0d", i), ack0, (i == 3 || i == 11));
      checkOutput($sformatf("rr ack1 c%0d", i), ack1, (i == 7 || i == 15));
      if (i == 1 || i == 9)  checkOutput($sformatf("rr addr c%0d", i), sAddr, 19'h00010);
      if (i == 5 || i == 13) checkOutput($sformatf("rr addr c%0d", i), sAddr, 19'h00020);
      if (i == 3 || i == 11) checkOutput($sformatf("rr rdata c%0d", i), rdata, 8'h11);
      if (i == 7 || i == 15) checkOutput($sformatf("rr rdata c%0d", i), rdata, 8'h22);
    end
    req0 = 0; req1 = 0;

    $display("[TB] late port 1 request is served after one port 0 access");
    req0 = 1; we0 = 0; addr0 = 19'h00100;
    @(posedge clk);
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      checkOutput($sformatf("sv ack0 c%0d", i), ack0, (i == 3 || i == 11));
      checkOutput($sformatf("sv ack1 c%0d", i), ack1, (i == 7));
      checkOutput($sformatf("sv busy c%0d", i), busy, !(i == 4 || i == 8 || i == 12));
      if (i == 1 || i == 9) checkOutput($sformatf("sv addr c%0d", i), sAddr, 19'h00100);
      if (i == 5) checkOutput("sv addr c5", sAddr, 19'h00200);
      if (i == 7) checkOutput("sv rdata c7", rdata, 8'hC3);
      if (i == 11) checkOutput("sv rdata c11", rdata, 8'h5A);
      if (i == 2) begin req1 = 1; we1 = 0; addr1 = 19'h00200; end
      if (i == 7) req1 = 0;
      if (i == 11) req0 = 0;
    end
    lastRd1 = 8'h5A;

    $display("[TB] reset during a write strobe");
    req0 = 1; we0 = 1; addr0 = 19'h00055; wdata0 = 8'h99;
    @(posedge clk);
    @(negedge clk);
    checkOutput("mid setup doe", doe, 1);
    @(negedge clk);
    checkOutput("mid strobe we_n", weN, 0);
    reset_n = 0; req0 = 0; we0 = 0;
    @(negedge clk);
    checkOutput("mid rst strobes", {ceN, weN, oeN}, 3'b111);
    checkOutput("mid rst doe", doe, 0);
    checkOutput("mid rst ack", {ack1, ack0}, 0);
    checkOutput("mid rst busy", busy, 0);
    checkOutput("mid rst addr/dout", {sAddr, dout}, 0);
    reset_n = 1;
    lastRd1 = 8'h00;
    @(negedge clk);
    checkOutput("after rst no ack", {ack1, ack0, busy}, 0);
    applyStimulus(0, 1, 19'h00055, 8'h66, 8'h00);
    applyStimulus(1, 0, 19'h00055, 8'h00, 8'h66);

    $display("[TB] three-cycle strobe instance");
    applyStimulus3(0, 19'h00ABC, 8'h00, 8'h77, 1);
    applyStimulus3(1, 19'h00DEF, 8'hE7, 8'h00, 0);
    checkOutput("w3 mem after write", mem3[19'h00DEF], 8'hE7);
    applyStimulus3(0, 19'h00DEF, 8'h00, 8'hE7, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
